// File: rtl/mem_responder_if.sv
// Request/response bus of the fixed-latency memory responder.
interface mem_responder_if;
  logic        enable;
  logic        wr;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_valid;
  logic        wr_ack;
  logic [3:0]  outstanding;

  modport master (
    output enable, wr, addr, data_in,
    input  data_out, data_valid, wr_ack, outstanding
  );

  modport slave (
    input  enable, wr, addr, data_in,
    output data_out, data_valid, wr_ack, outstanding
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word memory: every request walks a pipeline and touches the array
// only when it leaves the last stage, so all accesses complete in issue order.
module mem_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  mem_responder_if.slave bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  // The output registers act as the last stage, so LATENCY-1 request stages remain.
  localparam int unsigned NSTG  = (LATENCY > 1) ? LATENCY - 1 : 1;

  typedef struct packed {
    logic              valid;
    logic              wr;
    logic [ADDR_W-1:0] idx;
    logic [15:0]       data;
  } req_t;

  req_t        pipe_q [NSTG];
  req_t        pipe_d [NSTG];
  req_t        in_req;
  req_t        tail;

  logic [15:0] mem_q [DEPTH];

  logic [15:0] data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic        wr_ack_q, wr_ack_d;
  logic [3:0]  outstanding_q, outstanding_d;

  logic        unused_addr_hi;
  assign unused_addr_hi = ^bus.addr[15:ADDR_W];

  // Pipeline advance, completion decode and in-flight count.
  always_comb begin
    in_req = '{valid: bus.enable, wr: bus.wr, idx: bus.addr[ADDR_W-1:0], data: bus.data_in};
    for (int i = 0; i < int'(NSTG); i++) pipe_d[i] = '0;
    tail = in_req;
    if (LATENCY > 1) begin
      pipe_d[0] = in_req;
      for (int i = 1; i < int'(NSTG); i++) pipe_d[i] = pipe_q[i-1];
      tail = pipe_q[NSTG-1];
    end

    data_valid_d  = tail.valid & ~tail.wr;
    wr_ack_d      = tail.valid & tail.wr;
    data_out_d    = data_valid_d ? mem_q[tail.idx] : 16'h0000;

    outstanding_d = 4'(tail.valid);
    for (int i = 0; i < int'(NSTG); i++) begin
      outstanding_d = outstanding_d + 4'(pipe_d[i].valid);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NSTG); i++) pipe_q[i] <= '0;
      data_out_q    <= 16'h0000;
      data_valid_q  <= 1'b0;
      wr_ack_q      <= 1'b0;
      outstanding_q <= 4'd0;
    end else begin
      pipe_q        <= pipe_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      wr_ack_q      <= wr_ack_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Writes commit only on a non-reset edge; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_ack_d) begin
      mem_q[tail.idx] <= tail.data;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.wr_ack      = wr_ack_q;
  assign bus.outstanding = outstanding_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 10: word-address bits used; addr[15:ADDR_W] ignored.
REQ-002 Parameter LATENCY, default 4, legal 1..8: cycles from request capture to response.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  request valid this cycle.
REQ-006 wr  input  1  1 = write, 0 = read; ignored when enable=0.
REQ-007 addr  input  16  word address.
REQ-008 data_in  input  16  write data, sampled with the request.
REQ-009 data_out  output  16  read data; valid only while data_valid=1.
REQ-010 data_valid  output  1  one-cycle pulse per completed read.
REQ-011 wr_ack  output  1  one-cycle pulse per committed write.
REQ-012 outstanding  output  4  count of in-flight requests, 0..LATENCY.

Function
REQ-013 Storage SHALL be 2^ADDR_W words of 16 bits, word-addressed with index addr[ADDR_W-1:0]; addresses at or above 2^ADDR_W wrap.
REQ-014 A request SHALL be captured on every rising edge where enable=1; no back-pressure; one request per cycle accepted unconditionally.
REQ-015 Captured requests SHALL travel a LATENCY-stage pipeline holding valid, wr, index, and write data per stage.
REQ-016 The array SHALL be accessed only at the final stage, so reads and writes complete in strict issue order.
REQ-017 A read captured at edge N SHALL drive data_valid=1 and data_out=mem[index] during the cycle following edge N+LATENCY-1, i.e. exactly LATENCY cycles after the request cycle.
REQ-018 A write captured at edge N SHALL update mem[index] and pulse wr_ack=1 in that same completion cycle; data_valid SHALL stay 0 for it.
REQ-019 Read-after-write to the same index, in any order of issue cycles including back-to-back, SHALL return the newer written value.
REQ-020 Write-after-read to the same index SHALL return the old value to the earlier read.
REQ-021 When no read completes, data_valid=0 and data_out SHALL hold 16'h0000.
REQ-022 outstanding SHALL equal the number of valid pipeline stages after each edge; with continuous enable=1 it saturates at LATENCY and never exceeds it.
REQ-023 Cycles with enable=0 SHALL insert bubbles that produce no response and leave the array unchanged.
REQ-024 data_valid and wr_ack SHALL never both be 1 in the same cycle.

Reset
REQ-025 On a rising edge with rst=1, all pipeline valid bits, data_valid, wr_ack, and outstanding SHALL clear to 0 and data_out SHALL clear to 16'h0000.
REQ-026 Reset SHALL take priority over enable; a request presented with rst=1 SHALL be dropped.
REQ-027 In-flight requests at reset SHALL be discarded; uncommitted writes SHALL NOT reach the array, and earlier-committed contents SHALL be preserved.
REQ-028 Array contents SHALL NOT be cleared by reset; they are undefined until written.

Verification (LATENCY=4, ADDR_W=10)
REQ-029 Write 0x0010<-0xBEEF at cycle 0, read 0x0010 at cycle 1 -> wr_ack at cycle 4, data_valid with data_out=0xBEEF at cycle 5.
REQ-030 Back-to-back reads of 0x0000..0x0007 after preloading value=addr+0x100 -> data_valid high for cycles 4..11 returning 0x100..0x107 in order; outstanding=4 during the steady state.
REQ-031 Write 0x0405<-0x1234, then read 0x0005 -> returns 0x1234, confirming address wrap.
REQ-032 Read 0x0020 (old value 0x1111) at cycle 0, write 0x0020<-0x2222 at cycle 1, read at cycle 2 -> responses 0x1111 at cycle 4, wr_ack at cycle 5, 0x2222 at cycle 6.
REQ-033 Write 0x0030<-0xAAAA at cycle 0, rst=1 at cycle 2 -> no wr_ack, outstanding=0 after the reset edge, and a later read of 0x0030 returns its pre-reset value.
REQ-034 Alternate enable=1/0 with mixed reads and writes for 200 random cycles -> results match a reference model, and data_valid and wr_ack are never high together.
